// File: rtl/lane_scroll_sched.sv
// lane_scroll_sched: time-shared scroll-offset updater for NUM_LANES obstacle lanes.
// A free-running tick counter sets the update period; on every tick the FSM walks the
// lanes one per clock through a single add/subtract-with-wrap datapath.
// Optional feature macro: SCROLL_SPEEDUP_EN (periodic step boost, saturating at +7).
module lane_scroll_sched #(
  parameter int NUM_LANES     = 4,
  parameter int TICK_CYCLES   = 250000,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SPEEDUP_TICKS = 500,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cfg_we,
  input  logic [LW-1:0]           cfg_lane,
  input  logic [3:0]              cfg_step,
  input  logic                    cfg_dir,
  output logic [10*NUM_LANES-1:0] h_pos_flat,
  output logic                    busy,
  output logic                    sweep_done
);

  localparam int              TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [LW-1:0]   LANE_LAST = LW'(NUM_LANES - 1);
  localparam logic [10:0]     WIDTH11   = 11'(SCREEN_WIDTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_ctr_q, tick_ctr_d;
  logic [LW-1:0] lane_idx_q, lane_idx_d;
  logic          sweep_done_q, sweep_done_d;
  logic          tick_fire;
  logic          upd_en;

  logic [NUM_LANES-1:0][9:0] pos_all;
  logic [NUM_LANES-1:0][3:0] sh_step_all;
  logic [NUM_LANES-1:0]      sh_dir_all;
  logic [2:0]                boost;

  logic [9:0]  cur_pos;
  logic [3:0]  cur_step;
  logic        cur_dir;
  logic [10:0] pos_ext;
  logic [10:0] step_ext;
  logic [10:0] sum_ext;
  logic [10:0] res_ext;
  logic [9:0]  upd_pos;

  // Next-state logic: counting is gated by pause in both RUN and PAUSED, so releasing
  // pause resumes counting on the very same cycle the FSM returns to RUN.
  always_comb begin
    state_d      = state_q;
    tick_ctr_d   = tick_ctr_q;
    lane_idx_d   = lane_idx_q;
    sweep_done_d = 1'b0;
    tick_fire    = 1'b0;
    upd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN, ST_PAUSED: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick_ctr_q == TICK_LAST) begin
          tick_ctr_d = '0;
          lane_idx_d = '0;
          tick_fire  = 1'b1;
          state_d    = ST_UPDATE;
        end else begin
          tick_ctr_d = tick_ctr_q + TW'(1);
          state_d    = ST_RUN;
        end
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (lane_idx_q == LANE_LAST) begin
          lane_idx_d   = '0;
          sweep_done_d = 1'b1;
          state_d      = pause ? ST_PAUSED : ST_RUN;
        end else begin
          lane_idx_d = lane_idx_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, tick counter, lane pointer and the sweep-complete pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tick_ctr_q   <= '0;
      lane_idx_q   <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_ctr_q   <= tick_ctr_d;
      lane_idx_q   <= lane_idx_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Shared datapath: one wrap-around add or subtract for whichever lane is selected
  always_comb begin
    cur_pos  = pos_all[lane_idx_q];
    cur_step = sh_step_all[lane_idx_q];
    cur_dir  = sh_dir_all[lane_idx_q];
    pos_ext  = {1'b0, cur_pos};
    step_ext = {7'd0, cur_step};
    sum_ext  = pos_ext + step_ext;
    if (!cur_dir) begin
      res_ext = (sum_ext >= WIDTH11) ? (sum_ext - WIDTH11) : sum_ext;
    end else begin
      res_ext = (pos_ext < step_ext) ? (pos_ext + WIDTH11 - step_ext) : (pos_ext - step_ext);
    end
    upd_pos = 10'(res_ext);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [3:0] step_q;
      logic       dir_q;
      logic [3:0] sh_step_q;
      logic       sh_dir_q;
      logic [9:0] pos_q;
      logic [4:0] eff_sum;

      assign eff_sum = {1'b0, step_q} + {2'b0, boost};

      // Live config, tick-time shadow copy (step clamped at 15) and the lane offset
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          step_q    <= 4'd1;
          dir_q     <= 1'b0;
          sh_step_q <= 4'd1;
          sh_dir_q  <= 1'b0;
          pos_q     <= '0;
        end else begin
          if (cfg_we && (cfg_lane == LW'(gi))) begin
            step_q <= cfg_step;
            dir_q  <= cfg_dir;
          end
          if (tick_fire) begin
            sh_step_q <= eff_sum[4] ? 4'd15 : eff_sum[3:0];
            sh_dir_q  <= dir_q;
          end
          if (upd_en && (lane_idx_q == LW'(gi))) begin
            pos_q <= upd_pos;
          end
        end
      end

      assign pos_all[gi]     = pos_q;
      assign sh_step_all[gi] = sh_step_q;
      assign sh_dir_all[gi]  = sh_dir_q;
    end
  endgenerate

`ifdef SCROLL_SPEEDUP_EN
  localparam int            SW       = $clog2(SPEEDUP_TICKS + 1);
  localparam logic [SW-1:0] SPD_LAST = SW'(SPEEDUP_TICKS - 1);

  logic [SW-1:0] spd_cnt_q;
  logic [2:0]    boost_q;

  // Count ticks; every SPEEDUP_TICKS ticks raise the boost by one, saturating at 7
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spd_cnt_q <= '0;
      boost_q   <= 3'd0;
    end else if (tick_fire) begin
      if (spd_cnt_q == SPD_LAST) begin
        spd_cnt_q <= '0;
        if (boost_q != 3'd7) boost_q <= boost_q + 3'd1;
      end else begin
        spd_cnt_q <= spd_cnt_q + SW'(1);
      end
    end
  end

  assign boost = boost_q;
`else
  // No speedup: boost is pinned to zero (the parameter stays referenced in this build)
  assign boost = 3'(SPEEDUP_TICKS) & 3'd0;
`endif

  assign h_pos_flat = pos_all;
  assign busy       = (state_q == ST_UPDATE);
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_lane_scroll_sched.sv
// tb_lane_scroll_sched: table-driven wrap vectors, hand-written timing sequences and a
// randomized run checked every cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_lane_scroll_sched;

  localparam int N   = 4;
  localparam int T   = 10;
  localparam int W   = 640;
  localparam int SPD = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, pause, cfg_we;
  logic [1:0]  cfg_lane;
  logic [3:0]  cfg_step;
  logic        cfg_dir;
  logic [39:0] h_pos_flat;
  logic        busy, sweep_done;

  logic        cfg3_we;
  logic [1:0]  cfg3_lane;
  logic [3:0]  cfg3_step;
  logic        cfg3_dir;
  logic [29:0] h3_flat;
  logic        busy3, done3;

  always #5 clk = ~clk;

  lane_scroll_sched #(.NUM_LANES(N), .TICK_CYCLES(T), .SCREEN_WIDTH(W), .SPEEDUP_TICKS(SPD)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .cfg_we(cfg_we),
    .cfg_lane(cfg_lane), .cfg_step(cfg_step), .cfg_dir(cfg_dir),
    .h_pos_flat(h_pos_flat), .busy(busy), .sweep_done(sweep_done)
  );

  // Three-lane instance: lane index 3 is representable but out of range
  lane_scroll_sched #(.NUM_LANES(3), .TICK_CYCLES(T), .SCREEN_WIDTH(W), .SPEEDUP_TICKS(SPD)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .cfg_we(cfg3_we),
    .cfg_lane(cfg3_lane), .cfg_step(cfg3_step), .cfg_dir(cfg3_dir),
    .h_pos_flat(h3_flat), .busy(busy3), .sweep_done(done3)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: positions as integers, wrap via modulo, tick as a countdown of
  // un-paused cycles, sweep as "which lane is written on the next edge".
  int m_pos[N];
  int m_step[N];
  int m_dir[N];
  int m_sh_step[N];
  int m_sh_dir[N];
  bit m_started;
  int m_elapsed;
  int m_sweep;
  bit m_done;
  int m_boost;
`ifdef SCROLL_SPEEDUP_EN
  int m_ticks;
`endif

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pos[k] = 0; m_step[k] = 1; m_dir[k] = 0; m_sh_step[k] = 1; m_sh_dir[k] = 0;
    end
    m_started = 0; m_elapsed = 0; m_sweep = -1; m_done = 0; m_boost = 0;
`ifdef SCROLL_SPEEDUP_EN
    m_ticks = 0;
`endif
  endtask

  task automatic model_step();
    m_done = 0;
    if (m_sweep >= 0) begin
      int s = m_sh_step[m_sweep];
      int d = (m_sh_dir[m_sweep] != 0) ? -s : s;
      m_pos[m_sweep] = ((m_pos[m_sweep] + d) % W + W) % W;
      if (m_sweep == N - 1) begin
        m_sweep = -1;
        m_done  = 1;
      end else begin
        m_sweep++;
      end
    end else if (!m_started) begin
      m_started = start;
    end else if (!pause) begin
      if (m_elapsed == T - 1) begin
        m_elapsed = 0;
        for (int k = 0; k < N; k++) begin
          m_sh_step[k] = (m_step[k] + m_boost > 15) ? 15 : m_step[k] + m_boost;
          m_sh_dir[k]  = m_dir[k];
        end
`ifdef SCROLL_SPEEDUP_EN
        m_ticks++;
        if (m_ticks == SPD) begin
          m_ticks = 0;
          if (m_boost < 7) m_boost++;
        end
`endif
        m_sweep = 0;
      end else begin
        m_elapsed++;
      end
    end
    if (cfg_we && int'(cfg_lane) < N) begin
      m_step[cfg_lane] = int'(cfg_step);
      m_dir[cfg_lane]  = int'(cfg_dir);
    end
  endtask

  // One clock: advance model on the edge, then compare all outputs 1 ns later
  task automatic cyc();
    logic [39:0] exp_flat;
    logic        exp_busy;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < N; k++) exp_flat[10*k +: 10] = 10'(m_pos[k]);
    exp_busy = (m_sweep >= 0);
    checks++;
    if ({h_pos_flat, busy, sweep_done} !== {exp_flat, exp_busy, m_done}) begin
      failures++;
      $display("FAIL model_cycle actual=%h/%b/%b required=%h/%b/%b",
               h_pos_flat, busy, sweep_done, exp_flat, exp_busy, m_done);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; pause = 1'b0;
    cfg_we = 1'b0; cfg_lane = '0; cfg_step = '0; cfg_dir = 1'b0;
    cfg3_we = 1'b0; cfg3_lane = '0; cfg3_step = '0; cfg3_dir = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic cfg_write(input int lane, input int step, input int dir);
    cfg_we = 1'b1; cfg_lane = 2'(lane); cfg_step = 4'(step); cfg_dir = 1'(dir);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!sweep_done && n < budget);
    chk(name, 64'(sweep_done), 64'd1);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!busy && n < budget);
    chk(name, 64'(busy), 64'd1);
  endtask

  function automatic logic [39:0] all_lanes(input int v);
    logic [39:0] r;
    for (int k = 0; k < N; k++) r[10*k +: 10] = 10'(v);
    return r;
  endfunction

`ifndef SCROLL_SPEEDUP_EN
  typedef struct {
    int lane; int step1; int dir1; int ticks1;
    int step2; int dir2; int ticks2;
    int exp_pos; int exp_other;
  } vec_t;
  vec_t vecs[6];
`endif

  int exp6[7];

  initial begin
`ifndef SCROLL_SPEEDUP_EN
    vecs[0] = '{2, 2,  0, 319, 5,  0, 1, 3,   320};  // preset 638, +5 wraps to 3
    vecs[1] = '{1, 4,  0, 1,   7,  1, 1, 637, 2};    // 4 - 7 wraps to 637
    vecs[2] = '{0, 15, 1, 1,   0,  0, 5, 625, 6};    // step 0 holds position
    vecs[3] = '{3, 15, 0, 42,  10, 0, 1, 0,   43};   // 630 + 10 == W lands on 0
    vecs[4] = '{1, 3,  1, 1,   13, 0, 1, 10,  2};    // 637 + 13 wraps to 10
    vecs[5] = '{2, 1,  1, 1,   1,  0, 1, 0,   2};    // 0 - 1 -> 639, then +1 -> 0
`endif
`ifdef SCROLL_SPEEDUP_EN
    exp6 = '{14, 28, 42, 57, 72, 87, 102};
`else
    exp6 = '{14, 28, 42, 56, 70, 84, 98};
`endif

    // Reset state and default sweep timing
    do_reset();
    chk("reset_h_pos", 64'(h_pos_flat), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sweep_done", 64'(sweep_done), 64'd0);
    chk("reset_h_pos_3lane", 64'(h3_flat), 64'd0);
    start = 1'b1;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("busy_rise", 64'(busy), 64'(i == 10));
    end
    for (int k = 0; k < N; k++) begin
      logic [39:0] e;
      e = '0;
      for (int j = 0; j <= k; j++) e[10*j +: 10] = 10'd1;
      cyc();
      chk("lane_walk", 64'(h_pos_flat), 64'(e));
      chk("sweep_done_pulse", 64'(sweep_done), 64'(k == N - 1));
    end
    cyc();
    chk("sweep_done_clear", 64'(sweep_done), 64'd0);
    chk("busy_fall", 64'(busy), 64'd0);

    // Pause with tick counter at 6, hold 100 cycles, resume
    repeat (5) cyc();
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("paused_hold", 64'({h_pos_flat, busy}), 64'({all_lanes(1), 1'b0}));
    end
    pause = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("resume_busy", 64'(busy), 64'(i == 4));
    end

    // Pause raised mid-sweep: remaining lanes still update, then FSM parks
    cyc();
    pause = 1'b1;
    repeat (3) cyc();
    chk("midsweep_pause_lanes", 64'(h_pos_flat), 64'(all_lanes(2)));
    chk("midsweep_pause_done", 64'(sweep_done), 64'd1);
    for (int i = 0; i < 30; i++) begin
      cyc();
      chk("parked_no_busy", 64'(busy), 64'd0);
    end
    chk("parked_lanes", 64'(h_pos_flat), 64'(all_lanes(2)));
    pause = 1'b0;

    // Config writes during a sweep only apply from the next tick; last write wins
    do_reset();
    start = 1'b1;
    wait_busy("cfg_wait_busy", 20);
    cfg_write(0, 3, 0);
    cfg_write(0, 9, 0);
    wait_done("cfg_sweep1", 20);
    chk("cfg_old_step", 64'(h_pos_flat), 64'(all_lanes(1)));
    wait_done("cfg_sweep2", 20);
    chk("cfg_new_step", 64'(h_pos_flat), 64'({10'd2, 10'd2, 10'd2, 10'd10}));

`ifndef SCROLL_SPEEDUP_EN
    // Table-driven wrap vectors
    for (int v = 0; v < 6; v++) begin
      do_reset();
      cfg_write(vecs[v].lane, vecs[v].step1, vecs[v].dir1);
      start = 1'b1;
      for (int t = 0; t < vecs[v].ticks1; t++) wait_done("vec_tick1", 20);
      cfg_write(vecs[v].lane, vecs[v].step2, vecs[v].dir2);
      for (int t = 0; t < vecs[v].ticks2; t++) wait_done("vec_tick2", 20);
      chk("vec_lane_pos", 64'(h_pos_flat[10*vecs[v].lane +: 10]), 64'(vecs[v].exp_pos));
      for (int k = 0; k < N; k++) begin
        if (k != vecs[v].lane) chk("vec_other_pos", 64'(h_pos_flat[10*k +: 10]), 64'(vecs[v].exp_other));
      end
    end
`endif

    // Out-of-range lane write dropped; step 14 with/without speedup
    do_reset();
    cfg3_we = 1'b1; cfg3_lane = 2'd3; cfg3_step = 4'd9; cfg3_dir = 1'b0;
    cyc();
    cfg3_lane = 2'd0; cfg3_step = 4'd2;
    cyc();
    cfg3_we = 1'b0;
    cfg_write(0, 14, 0);
    start = 1'b1;
    begin
      int n = 0;
      do begin
        cyc();
        n++;
      end while (!done3 && n < 20);
      chk("lane3_drop_done", 64'(done3), 64'd1);
      chk("lane3_drop_pos", 64'(h3_flat), 64'({10'd1, 10'd1, 10'd2}));
    end
    for (int t = 0; t < 7; t++) begin
      wait_done("speed_tick", 20);
      chk("speed_lane0", 64'(h_pos_flat[9:0]), 64'(exp6[t]));
    end

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start = (i > 5) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      cfg_we   = 1'($urandom_range(0, 9) == 0);
      cfg_lane = 2'($urandom);
      cfg_step = 4'($urandom);
      cfg_dir  = 1'($urandom);
      cyc();
    end
    cfg_we = 1'b0;
    pause  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
